// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: phase encodings, the opcode
// classes that take a second execute cycle, status bit positions and the
// halt instruction word.
package ctrl_pkg;

    typedef enum logic [1:0] {
        PH_FETCH = 2'b00,
        PH_EX0   = 2'b01,
        PH_EX1   = 2'b10,
        PH_HALT  = 2'b11
    } phase_e;

    localparam logic [2:0] OP_BRN   = 3'b111;
    localparam logic [2:0] OP_BRZ   = 3'b110;
    localparam logic [2:0] OP_LDSTR = 3'b001;
    localparam logic [2:0] OP_LDI   = 3'b100;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of the instruction-memory handshake, ALU flag inputs and the
// sequencer outputs that feed the EX0/EX1 control units.
// master: the sequencer; slave: memory/datapath side.
interface control_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic [15:0]         mem_rdata;
    logic                mem_ready;
    logic                mem_req;
    logic [3:0]          alu_status;
    logic                status_we;
    logic [15:0]         ir;
    logic [3:0]          status;
    logic [1:0]          phase;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  mem_rdata, mem_ready, alu_status, status_we,
        output mem_req, ir, status, phase, retired
    );

    modport slave (
        output mem_rdata, mem_ready, alu_status, status_we,
        input  mem_req, ir, status, phase, retired
    );
endinterface

// File: rtl/ex1_need_decode.sv
// Opcode class decode: which instructions need the second execute cycle.
// Also instantiated by the EX1 control unit so both sides agree.
module ex1_need_decode
    import ctrl_pkg::*;
(
    input  logic [2:0] op_i,
    output logic       need_ex1_o
);

    // Branches, load/store and load-immediate all use EX1.
    always_comb begin
        need_ex1_o = 1'b0;
        case (op_i)
            OP_BRN, OP_BRZ, OP_LDSTR, OP_LDI: need_ex1_o = 1'b1;
            default:                          need_ex1_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/EX0/EX1 sequencer with instruction register, latched
// ALU flags and a retired-instruction counter.
// Optional feature macro: CTRL_SEQ_HALT_EN (16'hFFFF parks the machine in HALT).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PH_FETCH | request instruction, load ir when memory is ready
// PH_EX0   | first execute cycle, always one cycle
// PH_EX1   | second execute cycle for branch / load-store / LDI
// PH_HALT  | parked until reset (halt build only; else falls to FETCH)
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    control_sequencer_if.master bus
);

    localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    phase_e              state_q, state_d;
    logic [15:0]         ir_q, ir_d;
    logic [3:0]          status_q, status_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                need_ex1;

    ex1_need_decode u_ex1_need_decode (
        .op_i       (ir_q[13:11]),
        .need_ex1_o (need_ex1)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PH_FETCH;
            ir_q      <= 16'h0000;
            status_q  <= 4'h0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            status_q  <= status_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, instruction load, flag load and retire count.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        status_d  = status_q;
        retired_d = retired_q;

        // Flags load in either execute cycle, even on the transitioning cycle.
        if (bus.status_we && (state_q == PH_EX0 || state_q == PH_EX1)) begin
            status_d = bus.alu_status;
        end

        case (state_q)
            PH_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    state_d = PH_EX0;
                end
            end
            PH_EX0: begin
`ifdef CTRL_SEQ_HALT_EN
                if (ir_q == HALT_WORD) begin
                    state_d = PH_HALT;
                end else
`endif
                if (need_ex1) begin
                    state_d = PH_EX1;
                end else begin
                    state_d   = PH_FETCH;
                    retired_d = retired_q + RET_ONE;
                end
            end
            PH_EX1: begin
                state_d   = PH_FETCH;
                retired_d = retired_q + RET_ONE;
            end
            PH_HALT: begin
`ifdef CTRL_SEQ_HALT_EN
                state_d = PH_HALT;
`else
                state_d = PH_FETCH;
`endif
            end
            default: state_d = PH_FETCH;
        endcase
    end

    // Request is a pure decode of the state, masked while reset is held.
    assign bus.mem_req = (state_q == PH_FETCH) && !rst;
    assign bus.ir      = ir_q;
    assign bus.status  = status_q;
    assign bus.phase   = state_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-cycle vector table for the
// main flow plus hand sequences for the 16'hFFFF word and counter wrap.
module tb_control_sequencer;

    localparam int RW = 4;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [15:0] rdata;
        logic        swe;
        logic [3:0]  alu;
        logic [1:0]  e_phase;
        logic        e_req;
        logic [15:0] e_ir;
        logic [3:0]  e_status;
        logic [RW-1:0] e_ret;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[$];

    control_sequencer_if #(.RETIRE_W(RW)) bus ();

    control_sequencer #(.RETIRE_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic [15:0] rd,
                       input logic swe, input logic [3:0] alu,
                       input logic [1:0] ph, input logic req, input logic [15:0] ir,
                       input logic [3:0] st, input logic [RW-1:0] ret);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rdata = rd; v.swe = swe; v.alu = alu;
        v.e_phase = ph; v.e_req = req; v.e_ir = ir; v.e_status = st; v.e_ret = ret;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, then check the outputs of the current cycle.
    task automatic drive(input logic r, input logic rdy, input logic [15:0] rd,
                         input logic swe, input logic [3:0] alu);
        @(negedge clk);
        rst            = r;
        bus.mem_ready  = rdy;
        bus.mem_rdata  = rd;
        bus.status_we  = swe;
        bus.alu_status = alu;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] ph, input logic req,
                             input logic [15:0] ir, input logic [3:0] st, input logic [RW-1:0] ret);
        check({tag, ".phase"},   {30'd0, bus.phase},   {30'd0, ph});
        check({tag, ".mem_req"}, {31'd0, bus.mem_req}, {31'd0, req});
        check({tag, ".ir"},      {16'd0, bus.ir},      {16'd0, ir});
        check({tag, ".status"},  {28'd0, bus.status},  {28'd0, st});
        check({tag, ".retired"}, {{(32-RW){1'b0}}, bus.retired}, {{(32-RW){1'b0}}, ret});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst            = 1'b1;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 16'h0000;
        bus.status_we  = 1'b0;
        bus.alu_status = 4'h0;
        repeat (2) @(posedge clk);

        //   rst rdy rdata     swe alu       phase req ir        st       ret
        add(1, 0, 16'h0000, 0, 4'h0,   2'd0, 0, 16'h0000, 4'h0, 4'd0); // reset values
        add(0, 1, 16'h0000, 0, 4'h0,   2'd0, 1, 16'h0000, 4'h0, 4'd0); // first fetch
        add(0, 0, 16'h0000, 0, 4'h0,   2'd1, 0, 16'h0000, 4'h0, 4'd0); // EX0, single
        add(0, 1, 16'h3912, 0, 4'h0,   2'd0, 1, 16'h0000, 4'h0, 4'd1); // fetch BRN
        add(0, 0, 16'h0000, 1, 4'b0010,2'd1, 0, 16'h3912, 4'h0, 4'd1); // EX0 flag write
        add(0, 1, 16'hAAAA, 0, 4'h0,   2'd2, 0, 16'h3912, 4'h2, 4'd1); // EX1, ready ignored
        add(0, 0, 16'h0000, 1, 4'hF,   2'd0, 1, 16'h3912, 4'h2, 4'd2); // FETCH, flags ignored
        add(0, 0, 16'h0000, 0, 4'h0,   2'd0, 1, 16'h3912, 4'h2, 4'd2); // wait 2
        add(0, 0, 16'h0000, 0, 4'h0,   2'd0, 1, 16'h3912, 4'h2, 4'd2); // wait 3
        add(0, 1, 16'h0800, 0, 4'h0,   2'd0, 1, 16'h3912, 4'h2, 4'd2); // 4th: load LDR
        add(0, 0, 16'h0000, 1, 4'h5,   2'd1, 0, 16'h0800, 4'h2, 4'd2); // EX0 write 5
        add(0, 0, 16'h0000, 1, 4'h8,   2'd2, 0, 16'h0800, 4'h5, 4'd2); // EX1 write on exit
        add(0, 1, 16'h1800, 0, 4'h0,   2'd0, 1, 16'h0800, 4'h8, 4'd3); // fetch op 011
        add(0, 0, 16'h0000, 0, 4'h0,   2'd1, 0, 16'h1800, 4'h8, 4'd3); // EX0 -> FETCH
        add(0, 1, 16'h3000, 0, 4'h0,   2'd0, 1, 16'h1800, 4'h8, 4'd4); // fetch BRZ
        add(0, 0, 16'h0000, 0, 4'h0,   2'd1, 0, 16'h3000, 4'h8, 4'd4);
        add(0, 0, 16'h0000, 0, 4'h0,   2'd2, 0, 16'h3000, 4'h8, 4'd4);
        add(0, 1, 16'h2000, 0, 4'h0,   2'd0, 1, 16'h3000, 4'h8, 4'd5); // fetch LDI
        add(0, 0, 16'h0000, 0, 4'h0,   2'd1, 0, 16'h2000, 4'h8, 4'd5);
        add(1, 0, 16'h0000, 0, 4'h0,   2'd2, 0, 16'h2000, 4'h8, 4'd5); // rst during EX1
        add(1, 1, 16'h1234, 0, 4'h0,   2'd0, 0, 16'h0000, 4'h0, 4'd0); // held in reset
        add(0, 0, 16'h0000, 0, 4'h0,   2'd0, 1, 16'h0000, 4'h0, 4'd0); // request returns

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rdata, vecs[i].swe, vecs[i].alu);
            check_all($sformatf("vec%0d", i), vecs[i].e_phase, vecs[i].e_req,
                      vecs[i].e_ir, vecs[i].e_status, vecs[i].e_ret);
        end

        // 16'hFFFF: HALT in the halt build, BRN otherwise.
        drive(0, 1, 16'hFFFF, 0, 4'h0);
        check_all("ffff_fetch", 2'd0, 1'b1, 16'h0000, 4'h0, 4'd0);
        drive(0, 1, 16'h0000, 1, 4'h3);
        check_all("ffff_ex0", 2'd1, 1'b0, 16'hFFFF, 4'h0, 4'd0);
`ifdef CTRL_SEQ_HALT_EN
        for (int k = 0; k < 11; k++) begin
            drive(0, 1, 16'h0000, 1, 4'hC);
            check_all($sformatf("halt%0d", k), 2'd3, 1'b0, 16'hFFFF, 4'h3, 4'd0);
        end
        drive(1, 0, 16'h0000, 0, 4'h0);
        check_all("halt_rst", 2'd3, 1'b0, 16'hFFFF, 4'h3, 4'd0);
        drive(0, 0, 16'h0000, 0, 4'h0);
        check_all("halt_exit", 2'd0, 1'b1, 16'h0000, 4'h0, 4'd0);
`else
        drive(0, 0, 16'h0000, 0, 4'h0);
        check_all("ffff_ex1", 2'd2, 1'b0, 16'hFFFF, 4'h3, 4'd0);
        drive(0, 0, 16'h0000, 0, 4'h0);
        check_all("ffff_done", 2'd0, 1'b1, 16'hFFFF, 4'h3, 4'd1);
        drive(1, 0, 16'h0000, 0, 4'h0);
        drive(0, 0, 16'h0000, 0, 4'h0);
        check_all("post_rst", 2'd0, 1'b1, 16'h0000, 4'h0, 4'd0);
`endif

        // Retired counter wraps modulo 2^RW: 17 single-cycle instructions.
        for (int k = 1; k <= 17; k++) begin
            drive(0, 1, 16'h0000, 0, 4'h0);
            drive(0, 0, 16'h0000, 0, 4'h0);
            check($sformatf("wrap_ex0_%0d", k), {30'd0, bus.phase}, 32'd1);
        end
        drive(0, 0, 16'h0000, 0, 4'h0);
        check("wrap_retired", {{(32-RW){1'b0}}, bus.retired}, 32'd1);
        check("wrap_phase", {30'd0, bus.phase}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control sequencer that sits directly upstream of the execute-cycle control-word decoders. It fetches each 16-bit instruction over a ready/request memory handshake and holds it in the instruction register. It latches the 4-bit ALU status flags and steps the machine through FETCH, EX0 and (when required) EX1. Its `ir`, `status` and `phase` outputs drive the EX0/EX1 control units, whose control words the datapath consumes.

## Interface
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_rdata` in 16: instruction word from instruction memory.
- `mem_ready` in 1: memory has valid `mem_rdata` this cycle.
- `mem_req` out 1: fetch request to instruction memory.
- `alu_status` in 4: flags from the ALU: [0]=Z, [1]=N, [2]=C, [3]=V.
- `status_we` in 1: flag-load strobe from the active control word.
- `ir` out 16: current instruction register.
- `status` out 4: latched flags, same bit order as `alu_status`.
- `phase` out 2: 2'b00 FETCH, 2'b01 EX0, 2'b10 EX1, 2'b11 HALT (only with the halt feature compiled in).
- `retired` out RETIRE_W: count of completed instructions.

## Operation
- **FETCH**
  - `mem_req`=1.
  - If `mem_ready`=1: `ir`<=`mem_rdata`, go to EX0.
  - Otherwise stay in FETCH with `ir` unchanged.
- **EX0**
  - Always exactly one cycle.
  - Next state is EX1 if `ir[13:11]` is 3'b111 (BRN), 3'b110 (BRZ), 3'b001 (LDR/STR) or 3'b100 (LDI). Otherwise next state is FETCH and `retired` increments.
- **EX1**
  - Exactly one cycle.
  - Next state is FETCH; `retired` increments.
- **Status flags**
  - `status`<=`alu_status` when `status_we`=1 and `phase` is EX0 or EX1.
  - `status_we` is ignored in FETCH and HALT.
  - A write in EX0 is visible to the EX1 decoder in the next cycle. The BRN condition therefore sees flags as of the end of EX0.
- **Counter**
  - `retired` wraps modulo 2^RETIRE_W with no saturation.
- **Handshake rules**
  - `mem_req` is combinational from state: high only in FETCH and low while `rst`=1.
  - `mem_ready` outside FETCH is ignored.
  - `mem_rdata` is sampled only on the cycle where `mem_req` and `mem_ready` are both 1.
- **Reset**
  - Reset values: `phase`=FETCH, `ir`=16'h0000, `status`=4'h0, `retired`=0, `mem_req`=0.
  - Reset asserted mid-instruction (any phase) abandons it with no `retired` increment. The first fetch request appears in the cycle after `rst` deasserts.

## Timing
- Minimum latency is FETCH(1) + EX0(1) = 2 cycles for single-execute instructions and 3 cycles for EX1 instructions.
- Each memory wait cycle adds 1 cycle.
- `ir`, `status`, `phase` and `retired` are registered; only `mem_req` is combinational.
- Back-to-back: the FETCH request is asserted in the cycle immediately after the last execute cycle.
- If `status_we`=1 and the state transitions in the same cycle, the flags still load.

## Configuration
- Macro: `CTRL_SEQ_HALT_EN`.
- **Defined:**
  - A fetched `ir`==16'hFFFF goes EX0 -> HALT instead of FETCH, with no `retired` increment.
  - HALT holds all outputs with `mem_req`=0 until `rst`.
  - `phase`=2'b11 in HALT.
- **Undefined:**
  - 16'hFFFF follows normal decoding: `ir[13:11]`=3'b111, so it behaves as BRN.
  - The 2'b11 encoding is unreachable; if ever reached, the next state is FETCH.

## Structure
- **Shared package `ctrl_pkg`:**
  - phase enum (FETCH/EX0/EX1/HALT with the encodings above);
  - opcode constants OP_BRN=3'b111, OP_BRZ=3'b110, OP_LDSTR=3'b001, OP_LDI=3'b100;
  - status bit indices Z/N/C/V;
  - HALT_WORD=16'hFFFF.
- **Sub-module `ex1_need_decode`:** combinational `ir[13:11]` -> needs-EX1 flag. Shared with the EX1 control unit so both agree on which opcodes use EX1.

## Test plan
- Reset, then `mem_ready`=1 with `mem_rdata`=16'h0000 → `phase` goes FETCH→EX0→FETCH; `retired`=1 after 2 cycles.
- Fetch 16'h3912 (`ir[13:11]`=3'b111) → phases FETCH, EX0, EX1, FETCH; `retired` increments only at the end of EX1.
- `mem_ready` held low for 3 cycles → `mem_req`=1 throughout; `ir` unchanged; `phase` stays FETCH; on the 4th cycle `ir` loads.
- In EX0 apply `status_we`=1 with `alu_status`=4'b0010 → `status`=4'b0010 in EX1; `status_we`=1 in FETCH → `status` unchanged.
- Assert `rst` during EX1 → next cycle `phase`=FETCH, `ir`=0, `status`=0, `retired`=0, `mem_req`=0 until `rst` deasserts.
- With `CTRL_SEQ_HALT_EN`: fetch 16'hFFFF → `phase`=2'b11 after EX0, `mem_req` stays 0 for 10+ cycles; `rst` returns `phase` to FETCH.
